// File: rtl/mem_pkg.sv
// Shared types and defaults for the backing-memory controller.
// Imported by mem_array and mem_ctl.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } mem_state_t;

    localparam int MEM_LATENCY     = 4;
    localparam int MEM_BLOCK_WORDS = 4;
    localparam int MEM_DEPTH       = 1024;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/mem_array.sv
// Single-port main-memory word array.
// Synchronous write, combinational read on the same address.
module mem_array
    import mem_pkg::*;
#(
    parameter  int DEPTH = MEM_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_ctl.sv
// Block-fill memory controller: fixed access latency, then a
// linear burst of BLOCK_WORDS beats from the block base.
module mem_ctl
    import mem_pkg::*;
#(
    parameter  int LATENCY     = MEM_LATENCY,
    parameter  int BLOCK_WORDS = MEM_BLOCK_WORDS,
    parameter  int DEPTH       = MEM_DEPTH,
    localparam int BW          = $clog2(BLOCK_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [31:0]   memAddr,
    input  logic [31:0]   memWriteData,
    input  logic          MemReadDone,
    output logic          MemReadReady,
    output logic [31:0]   memReadData,
    output logic [BW-1:0] memBeat,
    output logic          busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_t    state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] base;

    logic [AW-1:0] widx;
    logic [AW-1:0] blk;
    logic [BW-1:0] rd_off;
    logic [AW-1:0] ram_addr;
    logic          we;
    logic [31:0]   rdata;
    logic          unused_addr;

    assign widx        = memAddr[AW+1:2];
    assign blk         = {widx[AW-1:BW], {BW{1'b0}}};
    assign unused_addr = ^{memAddr[31:AW+2], memAddr[1:0]};

    // Look one beat ahead so the data register loads with the strobe.
    assign rd_off   = (state == BURST) ? memBeat + 1'b1 : '0;
    assign we       = (state == IDLE) && MemWrite;
    assign ram_addr = (state == IDLE)
                    ? widx
                    : (base | {{(AW-BW){1'b0}}, rd_off});

    mem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .addr (ram_addr),
        .wdata(memWriteData),
        .rdata(rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            base         <= '0;
            MemReadReady <= 1'b0;
            memReadData  <= '0;
            memBeat      <= '0;
            busy         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A pending write always takes the cycle.
                    if (!MemWrite && MemRead && !MemReadDone) begin
                        base  <= blk;
                        cnt   <= CW'(LATENCY - 1);
                        busy  <= 1'b1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        MemReadReady <= 1'b1;
                        memReadData  <= rdata;
                        memBeat      <= '0;
                        state        <= BURST;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                BURST: begin
                    if (memBeat == BW'(BLOCK_WORDS - 1)) begin
                        MemReadReady <= 1'b0;
                        memReadData  <= '0;
                        memBeat      <= '0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        memReadData <= rdata;
                        memBeat     <= memBeat + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctl.sv
// Randomized self-checking bench for mem_ctl against a
// word-array reference model kept in the bench.
module tb_mem_ctl;

    localparam int LAT = 4;
    localparam int BWN = 4;
    localparam int DEP = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] memAddr = '0;
    logic [31:0] memWriteData = '0;
    logic        MemReadDone = 1'b0;
    logic        MemReadReady;
    logic [31:0] memReadData;
    logic [1:0]  memBeat;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEP];

    mem_ctl #(
        .LATENCY(LAT),
        .BLOCK_WORDS(BWN),
        .DEPTH(DEP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .memAddr     (memAddr),
        .memWriteData(memWriteData),
        .MemReadDone (MemReadDone),
        .MemReadReady(MemReadReady),
        .memReadData (memReadData),
        .memBeat     (memBeat),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEP);
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1;
        memAddr = a;
        memWriteData = d;
        @(posedge clk);
        model[widx(a)] = d;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    // Issue a fill; optionally raise a write when beat wb is seen.
    task automatic fill(input logic [31:0] a, input int wb,
                        input logic [31:0] wa, input logic [31:0] wd);
        int idx;
        int base;
        int n;
        bit hit;
        idx = widx(a);
        base = idx - (idx % BWN);
        MemWrite = 1'b0;
        MemReadDone = 1'b0;
        MemRead = 1'b1;
        memAddr = a;
        @(posedge clk);
        @(negedge clk);
        MemRead = 1'b0;
        memAddr = $urandom;
        n = 1;
        hit = 1'b0;
        while (n <= LAT + 20) begin
            if (MemReadReady) begin
                hit = 1'b1;
                break;
            end
            chk("wait_busy", {31'b0, busy}, 32'd1);
            @(negedge clk);
            n++;
        end
        chk("latency", n, LAT + 1);
        if (hit) begin
            for (int k = 0; k < BWN; k++) begin
                chk("rdy", {31'b0, MemReadReady}, 32'd1);
                chk("beat", {30'b0, memBeat}, k);
                chk("data", memReadData, model[(base + k) % DEP]);
                chk("burst_busy", {31'b0, busy}, 32'd1);
                if (k == wb) begin
                    MemWrite = 1'b1;
                    memAddr = wa;
                    memWriteData = wd;
                end
                @(negedge clk);
            end
            chk("end_rdy", {31'b0, MemReadReady}, 32'd0);
            chk("end_busy", {31'b0, busy}, 32'd0);
            chk("end_data", memReadData, 32'd0);
        end
        if (wb >= 0) begin
            @(posedge clk);
            model[widx(wa)] = wd;
            @(negedge clk);
            MemWrite = 1'b0;
        end
    endtask

    task automatic rst_chk(input string tag);
        #2 reset = 1'b0;
        #1;
        chk({tag, "_rdy"}, {31'b0, MemReadReady}, 32'd0);
        chk({tag, "_data"}, memReadData, 32'd0);
        chk({tag, "_beat"}, {30'b0, memBeat}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int op;
        bit seen;
        #2 reset = 1'b0;
        #1;
        chk("rst_rdy", {31'b0, MemReadReady}, 32'd0);
        chk("rst_data", memReadData, 32'd0);
        chk("rst_beat", {30'b0, memBeat}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < DEP; i++) begin
            wr(i << 2, i);
        end

        fill(32'h24, -1, '0, '0);

        wr(32'h20, 32'hDEADBEEF);
        fill(32'h2C, -1, '0, '0);

        MemWrite = 1'b1;
        MemRead = 1'b1;
        memAddr = 32'h0;
        memWriteData = 32'h5;
        @(posedge clk);
        model[0] = 32'h5;
        @(negedge clk);
        chk("both_idle", {31'b0, busy}, 32'd0);
        fill(32'h0, -1, '0, '0);

        fill(32'h0, 1, 32'h4, 32'hCAFE0001);
        fill(32'h0, -1, '0, '0);

        MemRead = 1'b1;
        memAddr = 32'h40;
        @(posedge clk);
        @(negedge clk);
        MemRead = 1'b0;
        @(negedge clk);
        chk("wait_pre_rst", {31'b0, busy}, 32'd1);
        rst_chk("rst_wait");
        fill(32'h40, -1, '0, '0);

        MemRead = 1'b1;
        memAddr = 32'h80;
        @(posedge clk);
        @(negedge clk);
        MemRead = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (MemReadReady && memBeat == 2'd2) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("beat2_seen", {31'b0, seen}, 32'd1);
        rst_chk("rst_beat2");
        fill(32'h84, -1, '0, '0);

        fill(32'h1000, -1, '0, '0);

        MemReadDone = 1'b1;
        MemRead = 1'b1;
        memAddr = 32'h10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("done_block", {31'b0, busy}, 32'd0);
        end
        MemRead = 1'b0;
        MemReadDone = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                wr($urandom, $urandom);
            end else if (op == 1) begin
                fill($urandom, -1, '0, '0);
            end else begin
                fill($urandom, $urandom_range(0, BWN - 1),
                     $urandom, $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
